instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the PC, issues word-aligned

---
 rtl/instruction_fetch_unit_pkg.sv | 22 ++
 rtl/instruction_fetch_unit_if.sv | 15 +
 rtl/instruction_fetch_unit_pc_register.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word widths, reset/bubble constants, fetch FSM encoding.
// Pure declarations; no timing or flow control of its own.
package mips_pkg;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT   = 32'h0000_0000;
    localparam int unsigned        IMEM_BYTES_DEFAULT  = 64;

    typedef enum logic [1:0] {
        FS_RUN   = 2'b00,
        FS_WAIT  = 2'b01,
        FS_FAULT = 2'b10
    } fetch_state_e;

    // A fetch address is illegal if not word aligned or outside [0, limit).
    function automatic logic pc_is_bad(input logic [ADDR_W-1:0] pc,
                                       input logic [ADDR_W-1:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
// Request (addr/req) is held by the initiator until the memory raises ready.
interface instruction_fetch_unit_if;
    import mips_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_instruction;
    logic               imem_ready;

    modport master (output imem_addr, output imem_req,
                    input  imem_instruction, input imem_ready);
    modport slave  (input  imem_addr, input imem_req,
                    output imem_instruction, output imem_ready);
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop: load beats increment beats hold; sync reset to RESET_PC.
// Updates on the edge after load_en/inc_en; no backpressure of its own.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives pc to instruction memory and loads IF/ID on the consuming edge (1 cycle with ready=1).
// Memory backpressure (ready low) parks the address and inserts bubbles; stall holds PC and IF/ID.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned        IMEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    instruction_fetch_unit_if.master    imem,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    output logic [INSTR_W-1:0]          if_id_instruction,
    output logic [ADDR_W-1:0]           if_id_pc_plus4,
    output logic                        if_id_valid,
    output logic                        fetch_fault
);
    localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;

    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clock    (clock),
        .reset    (reset),
        .load_en  (pc_load),
        .load_val (pc_load_val),
        .inc_en   (pc_inc),
        .pc       (pc)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        pc_load     = 1'b0;
        pc_load_val = branch_target;
        pc_inc      = 1'b0;

        unique case (state_q)
            FS_RUN, FS_WAIT: begin
                if (pc_is_bad(pc, IMEM_LIMIT)) begin
                    fault_d = 1'b1;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = FS_FAULT;
                end else if (state_q == FS_RUN) begin
                    if (branch_taken) begin
                        // Redirect wins over stall and drops any word returned this cycle.
                        pc_load = 1'b1;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        state_d = FS_RUN;
                    end else if (imem.imem_ready) begin
                        instr_d = imem.imem_instruction;
                        pc4_d   = pc + ADDR_W'(4);
                        valid_d = 1'b1;
                        pc_inc  = 1'b1;
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        state_d = FS_WAIT;
                    end
                end else begin
                    // Address must stay stable while memory is busy, so a redirect is parked.
                    if (branch_taken) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = branch_target;
                        instr_d    = NOP_INSTR;
                        valid_d    = 1'b0;
                    end else if (imem.imem_ready && !stall) begin
                        state_d = FS_RUN;
                        if (pend_q) begin
                            pc_load     = 1'b1;
                            pc_load_val = pend_tgt_q;
                            pend_d      = 1'b0;
                            instr_d     = NOP_INSTR;
                            valid_d     = 1'b0;
                        end else begin
                            instr_d = imem.imem_instruction;
                            pc4_d   = pc + ADDR_W'(4);
                            valid_d = 1'b1;
                            pc_inc  = 1'b1;
                        end
                    end else if (!imem.imem_ready) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
            end
            FS_FAULT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
                state_d = FS_FAULT;
                fault_d = 1'b1;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FS_RUN;
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign imem.imem_addr    = pc;
    assign imem.imem_req     = (state_q != FS_FAULT);
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc4_q;
    assign if_id_valid       = valid_q;
    assign fetch_fault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random stimulus checked
// each cycle against a transaction-level model of the fetch rules.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [16];

    instruction_fetch_unit_if ifc ();

    instruction_fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .imem              (ifc),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_fault       (fetch_fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a < 32'd64) return mem[a[5:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb ifc.imem_instruction = mem_rd(ifc.imem_addr);

    // Reference model state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
    logic        m_valid, m_fault, m_wait, m_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic accept(input logic [31:0] word);
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic rst, input logic st, input logic br,
                              input logic [31:0] tgt, input logic rdy);
        logic [31:0] word;
        word = mem_rd(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_pc4 = 32'h0; m_fault = 1'b0;
            m_wait = 1'b0; m_pend = 1'b0;
            bubble();
        end else if (m_fault) begin
            bubble();
        end else if ((m_pc % 4) != 0 || m_pc >= 64) begin
            m_fault = 1'b1;
            bubble();
        end else if (!m_wait) begin
            if (br) begin
                m_pc = tgt; bubble();
            end else if (!st) begin
                if (rdy) accept(word);
                else begin bubble(); m_wait = 1'b1; end
            end
        end else begin
            if (br) begin
                m_pend = 1'b1; m_tgt = tgt; bubble();
            end else if (rdy && !st) begin
                m_wait = 1'b0;
                if (m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0; bubble();
                end else accept(word);
            end else if (!rdy) begin
                bubble();
            end
        end
    endtask

    task automatic compare_all();
        check("imem_addr", ifc.imem_addr, m_pc);
        check("imem_req", 32'(ifc.imem_req), 32'(!m_fault));
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("if_id_instruction", if_id_instruction, m_instr);
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (m_valid) check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
    task automatic cycle(input logic rst, input logic st, input logic br,
                         input logic [31:0] tgt, input logic rdy);
        reset = rst; stall = st; branch_taken = br;
        branch_target = tgt; ifc.imem_ready = rdy;
        @(posedge clock);
        model_step(rst, st, br, tgt, rdy);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h01098020; mem[1] = 32'h020A8822;
        mem[2] = 32'h02119020; mem[3] = 32'hAC0C0004;
        mem[5] = 32'h01A98020;
        ifc.imem_ready = 1'b1;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_tgt = 0;
        m_valid = 0; m_fault = 0; m_wait = 0; m_pend = 0;

        // 1: reset state and the forwarding program
        do_reset();
        check("rst_addr", ifc.imem_addr, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        run(1);
        check("t1_instr0", if_id_instruction, 32'h01098020);
        check("t1_pc4_0", if_id_pc_plus4, 32'd4);
        run(3);
        check("t1_instr3", if_id_instruction, 32'hAC0C0004);
        check("t1_pc4_3", if_id_pc_plus4, 32'd16);

        // 2: stall holds PC and IF/ID
        run(2);
        check("t2_pre_instr", if_id_instruction, 32'h01A98020);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_stall_addr", ifc.imem_addr, 32'd24);
        check("t2_stall_instr", if_id_instruction, 32'h01A98020);
        check("t2_stall_pc4", if_id_pc_plus4, 32'd24);
        run(1);
        check("t2_after_pc4", if_id_pc_plus4, 32'd28);
        check("t2_after_instr", if_id_instruction, mem[6]);

        // 3: branch redirect from pc=12
        do_reset(); run(3);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        check("t3_addr", ifc.imem_addr, 32'h0);
        check("t3_valid", 32'(if_id_valid), 32'h0);
        check("t3_instr", if_id_instruction, 32'h0);
        run(1);
        check("t3_next_instr", if_id_instruction, 32'h01098020);
        check("t3_next_pc4", if_id_pc_plus4, 32'd4);

        // 4: memory not ready with redirect parked during the wait
        do_reset(); run(2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_wait_addr", ifc.imem_addr, 32'd8);
        check("t4_wait_valid", 32'(if_id_valid), 32'h0);
        run(1);
        check("t4_drop_valid", 32'(if_id_valid), 32'h0);
        check("t4_redir_addr", ifc.imem_addr, 32'h0);
        run(1);
        check("t4_mem0", if_id_instruction, 32'h01098020);

        // 5: misaligned target and running off the end of memory
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h42, 1'b1);
        check("t5_pre_fault", 32'(fetch_fault), 32'h0);
        run(1);
        check("t5_fault", 32'(fetch_fault), 32'h1);
        check("t5_req", 32'(ifc.imem_req), 32'h0);
        run(3);
        check("t5_sticky", 32'(fetch_fault), 32'h1);
        do_reset();
        check("t5_clr_fault", 32'(fetch_fault), 32'h0);
        run(16);
        check("t5_pc64", ifc.imem_addr, 32'd64);
        run(1);
        check("t5_range_fault", 32'(fetch_fault), 32'h1);
        do_reset();
        check("t5_rst_pc", ifc.imem_addr, 32'h0);

        // 6: reset in WAIT discards a pending redirect
        run(1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        do_reset();
        check("t6_rst_addr", ifc.imem_addr, 32'h0);
        run(1);
        check("t6_instr", if_id_instruction, 32'h01098020);
        check("t6_addr", ifc.imem_addr, 32'd4);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic        r_rst, r_st, r_br, r_rdy;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 3);
            r_st  = ($urandom_range(0, 99) < 20);
            r_br  = ($urandom_range(0, 99) < 12);
            r_rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) r_tgt = $urandom_range(0, 80);
            else r_tgt = 32'($urandom_range(0, 15)) << 2;
            cycle(r_rst, r_st, r_br, r_tgt, r_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
